// File: rtl/barrett_3779_pkg.sv
// Shared constants for the q=3779 Barrett datapath: modulus, port widths,
// maximum frame length and the accumulator FSM state encoding.
package barrett_3779_pkg;

    localparam int BARRETT_Q       = 3779;
    localparam int BARRETT_IN_W    = 23;
    localparam int BARRETT_RES_W   = 12;
    localparam int BARRETT_MAX_LEN = 2048;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } accum_state_e;

endpackage

// File: rtl/mod_accum_3779.sv
// Frame accumulator feeding the q=3779 Barrett reducer: sums 12-bit residues
// per frame into a raw 23-bit total and holds it until the reducer takes it.
module mod_accum_3779
    import barrett_3779_pkg::*;
#(
    parameter int Q       = BARRETT_Q,
    parameter int MAX_LEN = BARRETT_MAX_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BARRETT_RES_W-1:0]  in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BARRETT_IN_W-1:0]   out_sum,
    output logic [BARRETT_RES_W-1:0]  out_count,
    output logic                      out_err_range,
    output logic                      out_err_len
);

    localparam logic [BARRETT_RES_W:0]   Q_CMP   = (BARRETT_RES_W + 1)'(Q);
    localparam logic [BARRETT_RES_W-1:0] MAX_CNT = BARRETT_RES_W'(MAX_LEN);

    accum_state_e               state_q, state_d;
    logic [BARRETT_IN_W-1:0]    acc_q, acc_d;
    logic [BARRETT_RES_W-1:0]   cnt_q, cnt_d;
    logic                       rng_q, rng_d;
    logic [BARRETT_IN_W-1:0]    osum_q, osum_d;
    logic [BARRETT_RES_W-1:0]   ocnt_q, ocnt_d;
    logic                       oerr_rng_q, oerr_rng_d;
    logic                       oerr_len_q, oerr_len_d;

    logic [BARRETT_IN_W-1:0]    acc_nxt;
    logic [BARRETT_RES_W-1:0]   cnt_nxt;
    logic                       rng_nxt;

    // Out-of-range residues are still summed; they only raise the sticky flag.
    assign acc_nxt = acc_q + {{(BARRETT_IN_W - BARRETT_RES_W){1'b0}}, in_data};
    assign cnt_nxt = cnt_q + 1'b1;
    assign rng_nxt = rng_q | ({1'b0, in_data} >= Q_CMP);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rng_d      = rng_q;
        osum_d     = osum_q;
        ocnt_d     = ocnt_q;
        oerr_rng_d = oerr_rng_q;
        oerr_len_d = oerr_len_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_nxt;
                    rng_d = rng_nxt;
                    if (in_last || (cnt_nxt == MAX_CNT)) begin
                        state_d    = HOLD;
                        osum_d     = acc_nxt;
                        ocnt_d     = cnt_nxt;
                        oerr_rng_d = rng_nxt;
                        oerr_len_d = ~in_last;
                    end
                end
            end
            HOLD: begin
                // Frame state clears on the handshake edge so the next beat starts from zero.
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    rng_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            rng_q      <= 1'b0;
            osum_q     <= '0;
            ocnt_q     <= '0;
            oerr_rng_q <= 1'b0;
            oerr_len_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rng_q      <= rng_d;
            osum_q     <= osum_d;
            ocnt_q     <= ocnt_d;
            oerr_rng_q <= oerr_rng_d;
            oerr_len_q <= oerr_len_d;
        end
    end

    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == HOLD);
    assign out_sum       = osum_q;
    assign out_count     = ocnt_q;
    assign out_err_range = oerr_rng_q;
    assign out_err_len   = oerr_len_q;

endmodule

// File: doc/mod_accum_3779.md
MOD_ACCUM_3779 -- requirements
Module: mod_accum_3779

Interface
REQ-001 Parameter Q, default 3779, modulus of the downstream Barrett reducer; used only for the range check.
REQ-002 Parameter MAX_LEN, default 2048, maximum beats per frame; MAX_LEN*4095 SHALL fit in 23 bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_data  input  12  residue to accumulate, nominally < Q.
REQ-008 in_last  input  1  final beat of the frame.
REQ-009 out_valid  output  1  frame sum available.
REQ-010 out_ready  input  1  downstream (23-bit Barrett input) accepts the sum.
REQ-011 out_sum  output  23  unreduced frame sum, the Barrett reducer's din_a.
REQ-012 out_count  output  12  beats in the frame, 1..MAX_LEN.
REQ-013 out_err_range  output  1  at least one beat in the frame had in_data >= Q.
REQ-014 out_err_len  output  1  frame was force-closed at MAX_LEN without in_last.

Function
REQ-015 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1; out_sum SHALL be transferred only in a cycle where out_valid and out_ready are both 1.
REQ-016 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 In ACCUM, each accepted beat SHALL add zero-extended in_data to a 23-bit accumulator and increment a 12-bit beat counter.
REQ-018 Any in_data >= Q SHALL still be accumulated unchanged, and SHALL set a range flag that stays set until the frame is output.
REQ-019 ACCUM->HOLD SHALL occur on an accepted beat with in_last=1, or on the accepted beat that makes the count equal to MAX_LEN.
REQ-020 On a MAX_LEN close with in_last=0, err_len SHALL be set; a beat with in_last=1 at exactly MAX_LEN SHALL close normally with err_len=0.
REQ-021 On that transition the outputs SHALL be registered from the sum and count including the closing beat; out_valid SHALL rise on the next cycle (latency 1 from the last accepted beat).
REQ-022 out_sum, out_count and the error flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 HOLD->ACCUM SHALL occur on the output handshake; the accumulator, counter and flags SHALL clear in the same edge. There SHALL be one bubble cycle between frames.
REQ-024 The accumulator SHALL never overflow (worst case 2048*4095 = 8386560 < 2^23); no saturation logic.
REQ-025 in_valid=0 cycles in ACCUM SHALL leave all state unchanged (gaps allowed mid-frame).
REQ-026 The block SHALL NOT perform modular reduction; out_sum is raw for the downstream Barrett stage.

Reset
REQ-027 rst=1 SHALL force state ACCUM, accumulator=0, counter=0, flags=0, out_valid=0, out_sum=0, out_count=0, and in_ready=1 from the first cycle after reset.
REQ-028 rst asserted mid-frame or in HOLD SHALL discard the partial or pending frame with no output handshake; rst SHALL override any simultaneous beat or handshake.

Structure
REQ-029 Package barrett_3779_pkg SHALL hold Q=3779, the Barrett width constants (input 23, residue 12), MAX_LEN, and the FSM state enum.
REQ-030 The block SHALL be a single module with no sub-module; the Barrett reducer is instantiated by the parent, not inside this block.

Verification
REQ-031 Beats 3778, 3778, 1 (last), out_ready=1 -> out_sum=7557, out_count=3, flags 0, out_valid 1 cycle after the last beat.
REQ-032 2048 beats of 4095, in_last only on the 2048th -> out_sum=8386560, count=2048, err_range=1, err_len=0.
REQ-033 2049 beats of 1, no in_last -> first frame sum=2048, err_len=1; next frame starts with the 2049th beat, sum=1 when it closes.
REQ-034 Frame 5 (last), out_ready held 0 for 10 cycles -> in_ready=0 and out_sum=5 stable throughout; handshake on cycle 11, in_ready=1 the next cycle.
REQ-035 Beats 100, 200, then rst=1 for one cycle, then 7 (last) -> out_sum=7, out_count=1.
REQ-036 Random in_valid gaps and out_ready backpressure over 1000 frames -> every sum and count matches the reference model, and no beat is lost or duplicated.
